mult_div_unit: RTL and testbench

Multi-cycle integer multiply/divide unit with architectural HI/LO registers for the MIPS datapath. It sits directly downstream of the register bank: `readData1` (rs) and `readData2` (rt) drive its operands, and the pipeline control stalls on `busy`. It implements MULT, MULTU, DIV, DIVU, MTHI and MTLO with a shift-based iterative datapath, using one iteration per operand bit. HI and LO are read continuously for MFHI and MFLO.

---
 rtl/mult_div_pkg.sv | 28 ++
 rtl/mult_div_unit_sign_adjust.sv | 39 +++
 rtl/mult_div_unit.sv | 176 +++++++++++++++++
 tb/tb_mult_div_unit.sv | 233 +++++++++++++++++++++++
 4 files changed

// File: rtl/mult_div_pkg.sv
// Shared types for the iterative HI/LO multiply/divide unit.
// Divider datapath is compiled in only with MULT_DIV_DIV_EN.
package mult_div_pkg;

  localparam int MD_WIDTH = 32;

  typedef enum logic [1:0] {
    OP_MULTU = 2'b00,
    OP_MULT  = 2'b01,
    OP_DIVU  = 2'b10,
    OP_DIV   = 2'b11
  } md_op_e;

  typedef enum logic [1:0] {
    IDLE   = 2'b00,
    CALC   = 2'b01,
    FINISH = 2'b10
  } md_state_e;

  function automatic logic op_is_signed(input logic [1:0] op);
    return (op == OP_MULT) || (op == OP_DIV);
  endfunction

  function automatic logic op_is_div(input logic [1:0] op);
    return op[1];
  endfunction

endpackage

// File: rtl/mult_div_unit_sign_adjust.sv
// Sign handling for signed ops: operand magnitudes at accept,
// conditional negation of product/quotient/remainder at finish.
module md_sign_adjust
  import mult_div_pkg::*;
#(
  parameter int WIDTH = MD_WIDTH
) (
  input  logic [1:0]         op_i,
  input  logic [WIDTH-1:0]   a_i,
  input  logic [WIDTH-1:0]   b_i,
  output logic [WIDTH-1:0]   mag_a_o,
  output logic [WIDTH-1:0]   mag_b_o,
  output logic               neg_res_o,
  output logic               neg_rem_o,
  input  logic               neg_res_i,
  input  logic               neg_rem_i,
  input  logic [2*WIDTH-1:0] prod_i,
  input  logic [WIDTH-1:0]   quo_i,
  input  logic [WIDTH-1:0]   rem_i,
  output logic [2*WIDTH-1:0] prod_o,
  output logic [WIDTH-1:0]   quo_o,
  output logic [WIDTH-1:0]   rem_o
);

  logic sa, sb;

  assign sa = op_is_signed(op_i) & a_i[WIDTH-1];
  assign sb = op_is_signed(op_i) & b_i[WIDTH-1];

  assign mag_a_o   = sa ? (~a_i + 1'b1) : a_i;
  assign mag_b_o   = sb ? (~b_i + 1'b1) : b_i;
  assign neg_res_o = sa ^ sb;
  assign neg_rem_o = sa;

  assign prod_o = neg_res_i ? (~prod_i + 1'b1) : prod_i;
  assign quo_o  = neg_res_i ? (~quo_i + 1'b1) : quo_i;
  assign rem_o  = neg_rem_i ? (~rem_i + 1'b1) : rem_i;

endmodule

// File: rtl/mult_div_unit.sv
// Multi-cycle MULT/MULTU/DIV/DIVU with HI/LO and MTHI/MTLO.
// Define MULT_DIV_DIV_EN to build the restoring divider.
module mult_div_unit
  import mult_div_pkg::*;
#(
  parameter int WIDTH = MD_WIDTH
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] operandA,
  input  logic [WIDTH-1:0] operandB,
  input  logic             hiWrite,
  input  logic             loWrite,
  input  logic [WIDTH-1:0] moveData,
  output logic             busy,
  output logic             done,
  output logic             divByZero,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int CW = $clog2(WIDTH);

  md_state_e          state_q;
  logic [1:0]         op_q;
  logic [CW-1:0]      cnt_q;
  logic [2*WIDTH-1:0] acc_q, acc_d;
  logic [WIDTH-1:0]   mcand_q;
  logic [WIDTH-1:0]   hi_q, lo_q;
  logic               busy_q, done_q;
  logic               neg_res_q, neg_rem_q;

  logic [WIDTH-1:0]   mag_a, mag_b;
  logic               neg_res, neg_rem;
  logic [2*WIDTH-1:0] prod_adj;
  logic [WIDTH-1:0]   quo_adj, rem_adj;
  logic [WIDTH:0]     msum;

  md_sign_adjust #(.WIDTH(WIDTH)) u_sign (
    .op_i      (op),
    .a_i       (operandA),
    .b_i       (operandB),
    .mag_a_o   (mag_a),
    .mag_b_o   (mag_b),
    .neg_res_o (neg_res),
    .neg_rem_o (neg_rem),
    .neg_res_i (neg_res_q),
    .neg_rem_i (neg_rem_q),
    .prod_i    (acc_q),
    .quo_i     (acc_q[WIDTH-1:0]),
    .rem_i     (acc_q[2*WIDTH-1:WIDTH]),
    .prod_o    (prod_adj),
    .quo_o     (quo_adj),
    .rem_o     (rem_adj)
  );

`ifdef MULT_DIV_DIV_EN
  logic [WIDTH-1:0] dvsr_q;
  logic             dz_q, dbz_q;
  logic [WIDTH:0]   shifted, trial;
`endif

  // One iteration: shift-add for multiply, restoring step for divide
  always_comb begin
    acc_d = acc_q;
    msum  = '0;
`ifdef MULT_DIV_DIV_EN
    shifted = '0;
    trial   = '0;
`endif
    if (!op_is_div(op_q)) begin
      msum  = {1'b0, acc_q[2*WIDTH-1:WIDTH]}
            + (acc_q[0] ? {1'b0, mcand_q} : '0);
      acc_d = {msum, acc_q[WIDTH-1:1]};
    end
`ifdef MULT_DIV_DIV_EN
    else begin
      shifted = {acc_q[2*WIDTH-1:WIDTH], acc_q[WIDTH-1]};
      trial   = shifted - {1'b0, dvsr_q};
      if (!trial[WIDTH])
        acc_d = {trial[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b1};
      else
        acc_d = {shifted[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b0};
    end
`endif
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= IDLE;
      op_q      <= OP_MULTU;
      cnt_q     <= '0;
      acc_q     <= '0;
      mcand_q   <= '0;
      hi_q      <= '0;
      lo_q      <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      neg_res_q <= 1'b0;
      neg_rem_q <= 1'b0;
`ifdef MULT_DIV_DIV_EN
      dvsr_q    <= '0;
      dz_q      <= 1'b0;
      dbz_q     <= 1'b0;
`endif
    end else begin
      done_q <= 1'b0;
`ifdef MULT_DIV_DIV_EN
      dbz_q  <= 1'b0;
`endif
      unique case (state_q)
        IDLE: begin
          if (start) begin
            op_q      <= op;
            mcand_q   <= mag_a;
            neg_res_q <= neg_res;
            neg_rem_q <= neg_rem;
            cnt_q     <= CW'(WIDTH-1);
            busy_q    <= 1'b1;
            if (op_is_div(op)) begin
`ifdef MULT_DIV_DIV_EN
              acc_q  <= {{WIDTH{1'b0}}, mag_a};
              dvsr_q <= mag_b;
              dz_q   <= (operandB == '0);
              state_q <= (operandB == '0) ? FINISH : CALC;
`else
              state_q <= FINISH;
`endif
            end else begin
              acc_q   <= {{WIDTH{1'b0}}, mag_b};
              state_q <= CALC;
            end
          end else begin
            if (hiWrite) hi_q <= moveData;
            if (loWrite) lo_q <= moveData;
          end
        end
        CALC: begin
          acc_q <= acc_d;
          cnt_q <= cnt_q - 1'b1;
          if (cnt_q == '0) state_q <= FINISH;
        end
        FINISH: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
          done_q  <= 1'b1;
          if (!op_is_div(op_q)) begin
            hi_q <= prod_adj[2*WIDTH-1:WIDTH];
            lo_q <= prod_adj[WIDTH-1:0];
          end
`ifdef MULT_DIV_DIV_EN
          else if (!dz_q) begin
            hi_q <= rem_adj;
            lo_q <= quo_adj;
          end
          dbz_q <= dz_q;
`endif
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign busy = busy_q;
  assign done = done_q;
  assign hi   = hi_q;
  assign lo   = lo_q;
`ifdef MULT_DIV_DIV_EN
  assign divByZero = dbz_q;
`else
  assign divByZero = 1'b0;
`endif

endmodule

// File: tb/tb_mult_div_unit.sv
// Self-checking bench for mult_div_unit: directed table,
// disturbance sequences and randomized ops against a model.
module tb_mult_div_unit;

  logic        clk = 1'b0;
  logic        reset, start, hiWrite, loWrite;
  logic [1:0]  op;
  logic [31:0] operandA, operandB, moveData;
  logic        busy, done, divByZero;
  logic [31:0] hi, lo;

  int n_total = 0;
  int n_pass  = 0;

`ifdef MULT_DIV_DIV_EN
  localparam bit DIV_EN = 1'b1;
`else
  localparam bit DIV_EN = 1'b0;
`endif

  // Model of the architectural HI/LO
  logic [31:0] m_hi = '0;
  logic [31:0] m_lo = '0;

  always #5 clk = ~clk;

  mult_div_unit dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .op        (op),
    .operandA  (operandA),
    .operandB  (operandB),
    .hiWrite   (hiWrite),
    .loWrite   (loWrite),
    .moveData  (moveData),
    .busy      (busy),
    .done      (done),
    .divByZero (divByZero),
    .hi        (hi),
    .lo        (lo)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string nm, input logic [63:0] act,
                     input logic [63:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
  endtask

  // Reference results from plain arithmetic
  task automatic model(input logic [1:0] o, input logic [31:0] a,
                       input logic [31:0] b, output logic [31:0] eh,
                       output logic [31:0] el, output logic edz,
                       output int ecyc);
    logic [63:0] p;
    longint sa, sb, q, r;
    eh = m_hi; el = m_lo; edz = 1'b0; ecyc = 34;
    case (o)
      2'b00: begin
        p = {32'd0, a} * {32'd0, b};
        eh = p[63:32]; el = p[31:0];
      end
      2'b01: begin
        sa = longint'($signed(a)); sb = longint'($signed(b));
        q = sa * sb;
        eh = q[63:32]; el = q[31:0];
      end
      default: begin
        if (!DIV_EN) ecyc = 2;
        else if (b == 0) begin ecyc = 2; edz = 1'b1; end
        else if (o == 2'b10) begin
          el = a / b; eh = a % b;
        end else begin
          sa = longint'($signed(a)); sb = longint'($signed(b));
          q = sa / sb; r = sa % sb;
          el = q[31:0]; eh = r[31:0];
        end
      end
    endcase
  endtask

  task automatic launch(input logic [1:0] o, input logic [31:0] a,
                        input logic [31:0] b);
    op = o; operandA = a; operandB = b; start = 1'b1;
    tick();
    start = 1'b0;
    operandA = $urandom; operandB = $urandom;
  endtask

  task automatic finish_op(input string nm, input int n0,
                           input logic [31:0] eh, input logic [31:0] el,
                           input logic edz, input int ecyc);
    int n = n0;
    bit bok = 1'b1;
    while (!done && n < 200) begin
      if (!busy) bok = 1'b0;
      tick();
      n++;
    end
    chk({nm, ".cycle"}, 64'(n), 64'(ecyc));
    chk({nm, ".busy_run"}, 64'(bok), 64'(1));
    chk({nm, ".busy_done"}, 64'(busy), 64'(0));
    chk({nm, ".hi"}, 64'(hi), 64'(eh));
    chk({nm, ".lo"}, 64'(lo), 64'(el));
    chk({nm, ".dz"}, 64'(divByZero), 64'(edz));
    m_hi = eh; m_lo = el;
  endtask

  task automatic run_op(input string nm, input logic [1:0] o,
                        input logic [31:0] a, input logic [31:0] b);
    logic [31:0] eh, el;
    logic edz;
    int ec;
    model(o, a, b, eh, el, edz, ec);
    launch(o, a, b);
    finish_op(nm, 1, eh, el, edz, ec);
  endtask

  task automatic move(input bit wh, input bit wl, input logic [31:0] d);
    hiWrite = wh; loWrite = wl; moveData = d;
    tick();
    hiWrite = 1'b0; loWrite = 1'b0;
    if (wh) m_hi = d;
    if (wl) m_lo = d;
    chk("move.hi", 64'(hi), 64'(m_hi));
    chk("move.lo", 64'(lo), 64'(m_lo));
  endtask

  typedef struct {
    logic [1:0]  o;
    logic [31:0] a, b, eh, el;
    bit          div;
  } vec_t;

  vec_t tbl[4];

  initial begin
    logic [31:0] eh, el;
    logic edz;
    int ec;
    bit seen;
    reset = 1'b1; start = 1'b0; op = 2'b00;
    operandA = '0; operandB = '0;
    hiWrite = 1'b0; loWrite = 1'b0; moveData = '0;
    tick(); tick();
    reset = 1'b0;
    chk("rst.busy", 64'(busy), 64'(0));
    chk("rst.done", 64'(done), 64'(0));
    chk("rst.dz", 64'(divByZero), 64'(0));
    chk("rst.hi", 64'(hi), 64'(0));
    chk("rst.lo", 64'(lo), 64'(0));

    tbl[0] = '{2'b00, 32'hFFFFFFFF, 32'hFFFFFFFF,
               32'hFFFFFFFE, 32'h00000001, 1'b0};
    tbl[1] = '{2'b01, 32'hFFFFFFFD, 32'd7,
               32'hFFFFFFFF, 32'hFFFFFFEB, 1'b0};
    tbl[2] = '{2'b11, 32'hFFFFFFF9, 32'd2,
               32'hFFFFFFFF, 32'hFFFFFFFD, 1'b1};
    tbl[3] = '{2'b11, 32'h80000000, 32'hFFFFFFFF,
               32'h00000000, 32'h80000000, 1'b1};
    foreach (tbl[i]) begin
      launch(tbl[i].o, tbl[i].a, tbl[i].b);
      if (tbl[i].div && !DIV_EN)
        finish_op($sformatf("tbl%0d", i), 1, m_hi, m_lo, 1'b0, 2);
      else
        finish_op($sformatf("tbl%0d", i), 1, tbl[i].eh, tbl[i].el,
                  1'b0, 34);
    end

    tick();
    move(1'b1, 1'b0, 32'h1234);
    move(1'b0, 1'b1, 32'h5678);
    launch(2'b10, 32'd100, 32'd0);
    finish_op("dz", 1, 32'h1234, 32'h5678, DIV_EN, 2);

    // Second start plus MTHI during a multiply are dropped
    tick();
    model(2'b01, 32'hFFFF0001, 32'h00012345, eh, el, edz, ec);
    launch(2'b01, 32'hFFFF0001, 32'h00012345);
    repeat (4) tick();
    start = 1'b1; hiWrite = 1'b1; moveData = 32'hDEAD;
    op = 2'b00; operandA = 32'h3; operandB = 32'h5;
    tick();
    start = 1'b0; hiWrite = 1'b0;
    finish_op("disturb", 6, eh, el, 1'b0, 34);
    seen = 1'b0;
    repeat (40) begin tick(); if (done) seen = 1'b1; end
    chk("disturb.no_extra_done", 64'(seen), 64'(0));

    // Reset mid-operation discards the result
    launch(2'b00, 32'h12345678, 32'h9ABCDEF0);
    repeat (9) tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    m_hi = '0; m_lo = '0;
    chk("midrst.busy", 64'(busy), 64'(0));
    chk("midrst.hi", 64'(hi), 64'(0));
    chk("midrst.lo", 64'(lo), 64'(0));
    seen = 1'b0;
    repeat (60) begin tick(); if (done) seen = 1'b1; end
    chk("midrst.no_done", 64'(seen), 64'(0));

    // Random ops, moves and back-to-back starts
    for (int i = 0; i < 40; i++) begin
      logic [1:0]  o;
      logic [31:0] a, b;
      o = 2'($urandom_range(0, 3));
      a = $urandom;
      case ($urandom_range(0, 4))
        0: b = 32'd0;
        1: b = 32'($urandom_range(1, 20));
        2: b = 32'hFFFFFFFF;
        default: b = $urandom;
      endcase
      if ($urandom_range(0, 3) == 0) begin
        tick();
        move(1'($urandom), 1'($urandom), $urandom);
      end
      run_op($sformatf("rnd%0d", i), o, a, b);
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
